// File: rtl/mem_dcache_ctrl.sv
// mem_dcache_ctrl: sequences MEM-stage loads/stores onto the Dcache port, stalling the pipeline until completion
module mem_dcache_ctrl #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              rw_i,
    input  logic [1:0]        width_i,
    input  logic              rdtype_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic              flush_i,
    output logic              dc_req_o,
    output logic              dc_rw_o,
    output logic [31:0]       dc_addr_o,
    output logic [3:0]        dc_wstrb_o,
    output logic [31:0]       dc_wdata_o,
    input  logic              dc_gnt_i,
    input  logic              dc_rvalid_i,
    input  logic [31:0]       dc_rdata_i,
    output logic              stall_o,
    output logic              rd_valid_o,
    output logic [31:0]       rd_data_o,
    output logic              misalign_o,
    output logic [PERF_W-1:0] stall_cnt_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t state, nxt;
    logic rw_q, rdtype_q, mis, acc;
    logic [1:0] width_q, s;
    logic [31:0] addr_q, data_q, rd_data_q, sh, ext;
    logic [PERF_W-1:0] cnt_q;
    assign mis = (width_i == 2'b01 && addr_i[0]) || (width_i[1] && addr_i[1:0] != 2'b00);
    assign acc = state == IDLE && req_i && !mis && !flush_i;
    assign s = addr_q[1:0];
    assign sh = dc_rdata_i >> {s, 3'b000};
    assign ext = width_q == 2'b00 ? {{24{!rdtype_q && sh[7]}}, sh[7:0]} :
                 width_q == 2'b01 ? {{16{!rdtype_q && sh[15]}}, sh[15:0]} : dc_rdata_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = acc ? REQ : IDLE;
            REQ:   nxt = flush_i ? IDLE : !dc_gnt_i ? REQ : dc_rvalid_i ? DONE : WAIT;
            WAIT:  nxt = dc_rvalid_i ? (flush_i ? IDLE : DONE) : flush_i ? DRAIN : WAIT;
            DRAIN: nxt = dc_rvalid_i ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        dc_req_o   = state == REQ;
        stall_o    = state == IDLE ? req_i && !mis : state == DRAIN ? req_i : state == REQ || state == WAIT;
        rd_valid_o = state == DONE && !rw_q;
        misalign_o = state == IDLE && req_i && mis;
        dc_rw_o    = rw_q;
        dc_addr_o  = {addr_q[31:2], 2'b00};
        dc_wstrb_o = !rw_q ? 4'b0000 : width_q == 2'b00 ? 4'b0001 << s : width_q == 2'b01 ? 4'b0011 << s : 4'b1111;
        dc_wdata_o = width_q == 2'b00 ? {4{data_q[7:0]}} : width_q == 2'b01 ? {2{data_q[15:0]}} : data_q;
        rd_data_o  = rd_data_q;
        stall_cnt_o = cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q <= 1'b0;
            rdtype_q <= 1'b0;
            width_q <= 2'b00;
            addr_q <= '0;
            data_q <= '0;
            rd_data_q <= '0;
            cnt_q <= '0;
        end else begin
            if (acc) begin
                rw_q <= rw_i;
                rdtype_q <= rdtype_i;
                width_q <= width_i;
                addr_q <= addr_i;
                data_q <= wr_data_i;
            end
            if (nxt == DONE && !rw_q) rd_data_q <= ext;
            if (stall_o && !(&cnt_q)) cnt_q <= cnt_q + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// tb_mem_dcache_ctrl: directed self-checking bench for mem_dcache_ctrl
module tb_mem_dcache_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic req_i = 0, rw_i = 0, rdtype_i = 0, flush_i = 0, dc_gnt_i = 0, dc_rvalid_i = 0;
    logic [1:0] width_i = 0;
    logic [31:0] addr_i = 0, wr_data_i = 0, dc_rdata_i = 0;
    logic dc_req_o, dc_rw_o, stall_o, rd_valid_o, misalign_o;
    logic [31:0] dc_addr_o, dc_wdata_o, rd_data_o;
    logic [3:0] dc_wstrb_o;
    logic [15:0] stall_cnt_o;
    int errs = 0, n = 0;
    mem_dcache_ctrl #(.PERF_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .rw_i(rw_i), .width_i(width_i), .rdtype_i(rdtype_i),
        .addr_i(addr_i), .wr_data_i(wr_data_i), .flush_i(flush_i), .dc_req_o(dc_req_o), .dc_rw_o(dc_rw_o),
        .dc_addr_o(dc_addr_o), .dc_wstrb_o(dc_wstrb_o), .dc_wdata_o(dc_wdata_o), .dc_gnt_i(dc_gnt_i),
        .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i), .stall_o(stall_o), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .misalign_o(misalign_o), .stall_cnt_o(stall_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic rw, input logic [1:0] w, input logic rt, input logic [31:0] a, input logic [31:0] d);
        req_i = 1; rw_i = rw; width_i = w; rdtype_i = rt; addr_i = a; wr_data_i = d;
    endtask
    task automatic zload(input string tag, input logic [1:0] w, input logic rt, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
        issue(0, w, rt, a, 0);
        tick();
        req_i = 0; dc_gnt_i = 1; dc_rvalid_i = 1; dc_rdata_i = rd;
        tick();
        dc_gnt_i = 0; dc_rvalid_i = 0; #1;
        chk({tag, "_valid"}, rd_valid_o, 1);
        chk({tag, "_data"}, rd_data_o, exp);
        tick();
    endtask
    task automatic zstore(input string tag, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] strb, input logic [31:0] wd);
        issue(1, w, 0, a, d);
        tick();
        req_i = 0; dc_gnt_i = 1; dc_rvalid_i = 1; #1;
        chk({tag, "_strb"}, dc_wstrb_o, strb);
        chk({tag, "_wdata"}, dc_wdata_o, wd);
        tick();
        dc_gnt_i = 0; dc_rvalid_i = 0; #1;
        chk({tag, "_novalid"}, rd_valid_o, 0);
        tick();
    endtask
    initial begin
        tick(); tick();
        chk("rst_req", dc_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_cnt", stall_cnt_o, 0);
        chk("rst_rdata", rd_data_o, 0);
        rst = 0;
        tick();
        // lb 0x1003, zero-wait
        issue(0, 2'b00, 0, 32'h1003, 0); #1;
        chk("t1_stall_idle", stall_o, 1);
        chk("t1_noreq_idle", dc_req_o, 0);
        tick();
        req_i = 0; dc_gnt_i = 1; dc_rvalid_i = 1; dc_rdata_i = 32'h80FFFFFF; #1;
        chk("t1_req", dc_req_o, 1);
        chk("t1_stall_req", stall_o, 1);
        chk("t1_addr", dc_addr_o, 32'h1000);
        chk("t1_strb", dc_wstrb_o, 0);
        tick();
        dc_gnt_i = 0; dc_rvalid_i = 0; #1;
        chk("t1_stall_done", stall_o, 0);
        chk("t1_valid", rd_valid_o, 1);
        chk("t1_data", rd_data_o, 32'hFFFFFF80);
        chk("t1_cnt", stall_cnt_o, 2);
        tick();
        chk("t1_valid_off", rd_valid_o, 0);
        // sh 0x2002, gnt after 3 cycles
        issue(1, 2'b01, 0, 32'h2002, 32'h0000BEEF);
        tick();
        req_i = 0; addr_i = 0; wr_data_i = 0;
        for (int i = 0; i < 4; i++) begin
            dc_gnt_i = (i == 3); #1;
            chk("t2_req", dc_req_o, 1);
            chk("t2_addr", dc_addr_o, 32'h2000);
            chk("t2_strb", dc_wstrb_o, 4'b1100);
            chk("t2_wdata", dc_wdata_o, 32'hBEEFBEEF);
            chk("t2_rw", dc_rw_o, 1);
            tick();
        end
        dc_gnt_i = 0; dc_rvalid_i = 1; #1;
        chk("t2_wait_req", dc_req_o, 0);
        chk("t2_wait_stall", stall_o, 1);
        tick();
        dc_rvalid_i = 0; #1;
        chk("t2_done_novalid", rd_valid_o, 0);
        chk("t2_done_stall", stall_o, 0);
        chk("t2_cnt", stall_cnt_o, 8);
        tick();
        // misaligned lw
        issue(0, 2'b10, 0, 32'h3001, 0); #1;
        chk("t3_mis", misalign_o, 1);
        chk("t3_req", dc_req_o, 0);
        chk("t3_stall", stall_o, 0);
        tick();
        req_i = 0; #1;
        chk("t3_mis_off", misalign_o, 0);
        chk("t3_idle", dc_req_o, 0);
        // lhu flushed in WAIT, then drained
        issue(0, 2'b01, 1, 32'h4002, 0);
        tick();
        req_i = 0; dc_gnt_i = 1;
        tick();
        dc_gnt_i = 0; flush_i = 1; #1;
        chk("t4_wait_stall", stall_o, 1);
        tick();
        flush_i = 0; issue(0, 2'b10, 0, 32'h5000, 0); #1;
        chk("t4_drain_stall", stall_o, 1);
        chk("t4_drain_req", dc_req_o, 0);
        tick();
        dc_rvalid_i = 1; dc_rdata_i = 32'h1234ABCD; #1;
        chk("t4_drain_novalid", rd_valid_o, 0);
        tick();
        dc_rvalid_i = 0; #1;
        chk("t4_idle_novalid", rd_valid_o, 0);
        chk("t4_idle_stall", stall_o, 1);
        chk("t4_idle_req", dc_req_o, 0);
        chk("t4_rdata_kept", rd_data_o, 32'hFFFFFF80);
        tick();
        chk("t4_new_req", dc_req_o, 1);
        chk("t4_new_addr", dc_addr_o, 32'h5000);
        req_i = 0; dc_gnt_i = 1; dc_rvalid_i = 1; dc_rdata_i = 32'hCAFEF00D;
        tick();
        dc_gnt_i = 0; dc_rvalid_i = 0; #1;
        chk("t4_valid", rd_valid_o, 1);
        chk("t4_data", rd_data_o, 32'hCAFEF00D);
        chk("t4_cnt", stall_cnt_o, 15);
        tick();
        zload("lbu", 2'b00, 1, 32'h7001, 32'h123480AB, 32'h00000080);
        zload("lh", 2'b01, 0, 32'h6002, 32'h80010000, 32'hFFFF8001);
        zload("lw", 2'b10, 0, 32'h8000, 32'hDEADBEEF, 32'hDEADBEEF);
        zload("lb", 2'b00, 0, 32'h9000, 32'h0000007F, 32'h0000007F);
        zstore("sb", 2'b00, 32'hA001, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
        zstore("sw", 2'b10, 32'hB000, 32'h11223344, 4'b1111, 32'h11223344);
        chk("cnt_27", stall_cnt_o, 27);
        // flush with gnt in REQ
        issue(0, 2'b10, 0, 32'hC000, 0);
        tick();
        req_i = 0; flush_i = 1; dc_gnt_i = 1; #1;
        chk("t5_req", dc_req_o, 1);
        tick();
        flush_i = 0; dc_gnt_i = 0; #1;
        chk("t5_req_off", dc_req_o, 0);
        chk("t5_stall_off", stall_o, 0);
        tick();
        chk("t5_stay_idle", dc_req_o, 0);
        chk("t5_novalid", rd_valid_o, 0);
        // reset in WAIT, then saturation
        issue(0, 2'b10, 0, 32'hD000, 0);
        tick();
        req_i = 0; dc_gnt_i = 1;
        tick();
        dc_gnt_i = 0; #1;
        chk("t6_wait_stall", stall_o, 1);
        rst = 1; #1;
        chk("t6_rst_stall", stall_o, 0);
        chk("t6_rst_req", dc_req_o, 0);
        chk("t6_rst_cnt", stall_cnt_o, 0);
        chk("t6_rst_addr", dc_addr_o, 0);
        chk("t6_rst_data", rd_data_o, 0);
        tick();
        rst = 0;
        issue(0, 2'b10, 0, 32'hE000, 0);
        repeat (65534) tick();
        chk("t6_cnt_fffe", stall_cnt_o, 16'hFFFE);
        repeat (2) tick();
        chk("t6_cnt_sat", stall_cnt_o, 16'hFFFF);
        repeat (4464) tick();
        chk("t6_cnt_hold", stall_cnt_o, 16'hFFFF);
        chk("t6_still_req", dc_req_o, 1);
        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
